// File: rtl/bus_memory.sv
// Word-addressed 32 x 32 RAM slave on the system bus with a registered read port.
// Every word is cleared by reset, so storage is built from resettable registers.
module bus_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic [DATA_W-1:0] mem_rd [DEPTH];
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  // Upper address bits are dropped, so 0x20..0xFF alias onto the 32 words.
  assign idx   = addr[IDX_W-1:0];
  assign wr_en = cen & wen;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_q <= '0;
        end else if (wr_en && (idx == IDX_W'(gi))) begin
          word_q <= din;
        end
      end

      assign mem_rd[gi] = word_q;
    end
  endgenerate

  // Only an enabled read drives data; idle and write cycles return zero.
  always_comb begin
    dout_d = '0;
    if (cen && !wen) begin
      dout_d = mem_rd[idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory: table-driven vectors plus hand-written reset,
// fill/readback and aliasing sequences.
module tb_bus_memory;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int total;
  int bad;

  typedef struct {
    logic        cen;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  bus_memory #(
    .DATA_W(32),
    .ADDR_W(8),
    .DEPTH (32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cen    (cen),
    .wen    (wen),
    .addr   (addr),
    .din    (din),
    .dout   (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL %s: dout=%h expected %h", name, dout, exp);
    end
  endtask

  // Drive one access, let one rising edge take it, then look at dout 1 ns later.
  task automatic apply(input logic c, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input string name);
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    $display("txn %s cen=%0b wen=%0b addr=%h din=%h dout=%h exp=%h",
             name, c, w, a, d, dout, exp);
    check(name, exp);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    cen     = 1'b0;
    wen     = 1'b0;
    addr    = 8'h00;
    din     = 32'h0;

    vecs[0]  = '{1'b0, 1'b1, 8'h03, 32'h0000DEAD, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h03, 32'h0,        32'h3};
    vecs[2]  = '{1'b1, 1'b1, 8'h07, 32'h12345678, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 8'h07, 32'h0,        32'h12345678};
    vecs[4]  = '{1'b1, 1'b1, 8'h21, 32'hA5A5A5A5, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 8'h01, 32'h0,        32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 1'b0, 8'hE1, 32'h0,        32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 1'b0, 8'h01, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'h1F, 32'h0,        32'h31};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 8'h1F, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 8'h1E, 32'h0,        32'h30};
    vecs[13] = '{1'b1, 1'b0, 8'h03, 32'hFFFFFFFF, 32'h3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'h0);
    reset_n = 1'b1;

    // Test 1: never-written read, then an asynchronous reset mid-cycle
    apply(1'b1, 1'b0, 8'h05, 32'h0, 32'h0, "rd05_after_reset");
    apply(1'b1, 1'b1, 8'h05, 32'h00000077, 32'h0, "wr05");
    apply(1'b1, 1'b0, 8'h05, 32'h0, 32'h00000077, "rd05_new");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_dout", 32'h0);
    #1;
    reset_n = 1'b1;
    apply(1'b1, 1'b0, 8'h05, 32'h0, 32'h0, "rd05_cleared");

    // Test 2: fill 0x01..0x1F with a BCD pattern, then sweep reads
    for (int a = 1; a < 32; a++) begin
      apply(1'b1, 1'b1, 8'(a), bcd(a), 32'h0, "fill_wr");
    end
    for (int a = 0; a < 32; a++) begin
      apply(1'b1, 1'b0, 8'(a), 32'h0, bcd(a), "sweep_rd");
    end

    // Tests 3-5: disable, write-cycle output, read-after-write, aliasing
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].cen, vecs[i].wen, vecs[i].addr, vecs[i].din,
            vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Test 6: reset after a populated memory clears every word
    apply(1'b1, 1'b0, 8'h09, 32'h0, 32'h9, "pre_reset_rd09");
    reset_n = 1'b0;
    #1;
    check("mid_op_reset_dout", 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      apply(1'b1, 1'b0, 8'(a), 32'h0, 32'h0, "post_reset_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
